// File: rtl/image_frame_packetizer_pkg.sv
// Shared types for the image frame packetizer: write-side FSM states,
// default widths and the {last, data} FIFO entry width.
package image_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      PAD    = 2'd2
   } PKT_STATE_T;

   localparam int PKT_LEN_W  = 24;
   localparam int PKT_DATA_W = 32;

   function automatic int pkt_entry_w(input int data_w);
      return data_w + 1;
   endfunction

   localparam int PKT_ENTRY_W = pkt_entry_w(PKT_DATA_W);

endpackage

// File: rtl/image_frame_packetizer_fifo.sv
// Single-clock FIFO with synchronous active-low reset. The read port is
// combinational from the head entry and forced to zero while empty.
module image_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr, r_rd_ptr;
   logic             w_push, w_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = i_wr_en && !o_full;
   assign w_pop   = i_rd_en && !o_empty;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/image_frame_packetizer.sv
// Frame packetizer: buffers pixels and regenerates last from the programmed
// frame length. Define PKT_PAD_EN to pad short frames with PAD_VALUE.
module image_frame_packetizer import image_pkg::*; #(
   parameter int                DATA_W     = PKT_DATA_W,
   parameter int                FIFO_DEPTH = 16,
   parameter int                LEN_W      = PKT_LEN_W,
   parameter logic [DATA_W-1:0] PAD_VALUE  = '0
) (
   input  logic              M_AXIS_ACLK,
   input  logic              M_AXIS_ARESETN,
   input  logic [LEN_W-1:0]  cfg_frame_len,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_eof,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              frame_done,
   output logic              err_short,
   output logic              err_long,
   input  logic              err_clr
);
   localparam int         ENTRY_W   = pkt_entry_w(DATA_W);
   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_STREAM = STREAM;
   localparam logic [1:0] ST_PAD    = PAD;

   logic [1:0]         r_state, w_state_nxt;
   logic [LEN_W-1:0]   r_len_q, r_beat_cnt, w_len, w_cnt, w_cnt_nxt;
   logic               r_err_short, r_err_long, r_frame_done;
   logic               w_full, w_empty, w_accept, w_pad_wr, w_wr_en, w_pop;
   logic               w_at_end, w_last, w_set_short, w_set_long;
   logic [ENTRY_W-1:0] w_wr_entry, w_rd_entry;

   assign s_ready  = M_AXIS_ARESETN && !w_full && (r_state != ST_PAD) &&
                     ((r_state != ST_IDLE) || (cfg_frame_len != '0));
   assign w_accept = s_valid && s_ready;

   // A beat taken in IDLE is beat 0 of a frame using the live config length.
   assign w_len    = (r_state == ST_IDLE) ? cfg_frame_len : r_len_q;
   assign w_cnt    = (r_state == ST_IDLE) ? '0 : r_beat_cnt;
   assign w_at_end = (w_cnt == w_len - LEN_W'(1));

`ifdef PKT_PAD_EN
   assign w_pad_wr = (r_state == ST_PAD) && !w_full;
   assign w_last   = w_at_end;
`else
   assign w_pad_wr = 1'b0;
   assign w_last   = w_at_end || s_eof;
`endif

   assign w_wr_en     = w_accept || w_pad_wr;
   assign w_wr_entry  = w_pad_wr ? {w_at_end, PAD_VALUE} : {w_last, s_data};
   assign w_set_short = w_accept && s_eof && !w_at_end;
   assign w_set_long  = w_accept && !s_eof && w_at_end;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_beat_cnt;
      if (w_wr_en) begin
         w_cnt_nxt = w_cnt + LEN_W'(1);
         if (w_at_end) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
`ifdef PKT_PAD_EN
         end else if (w_accept && s_eof) begin
            w_state_nxt = ST_PAD;
`else
         end else if (s_eof) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
`endif
         end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_STREAM;
         end
      end
   end

   always_ff @(posedge M_AXIS_ACLK) begin
      if (!M_AXIS_ARESETN) begin
         r_state      <= ST_IDLE;
         r_len_q      <= '0;
         r_beat_cnt   <= '0;
         r_err_short  <= 1'b0;
         r_err_long   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_beat_cnt   <= w_cnt_nxt;
         if (w_accept && (r_state == ST_IDLE)) r_len_q <= cfg_frame_len;
         r_err_short  <= w_set_short || (r_err_short && !err_clr);
         r_err_long   <= w_set_long  || (r_err_long  && !err_clr);
         r_frame_done <= w_pop && m_last;
      end
   end

   image_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (M_AXIS_ACLK),
      .i_rst_n   (M_AXIS_ARESETN),
      .i_wr_en   (w_wr_en),
      .i_wr_data (w_wr_entry),
      .i_rd_en   (w_pop),
      .o_rd_data (w_rd_entry),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign m_valid           = !w_empty;
   assign {m_last, m_data}  = w_rd_entry;
   assign w_pop             = m_valid && m_ready;
   assign frame_done        = r_frame_done;
   assign err_short         = r_err_short;
   assign err_long          = r_err_long;

endmodule

// File: tb/tb_image_frame_packetizer.sv
// Directed bench for image_frame_packetizer; expectations follow the
// PKT_PAD_EN setting the bench is compiled with.
module tb_image_frame_packetizer;
   localparam int DW = 32;
   localparam int LW = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [LW-1:0] cfg = '0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0, s_eof = 1'b0, s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid, m_last, m_ready = 1'b0;
   logic          frame_done, err_short, err_long, err_clr = 1'b0;

   int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
   logic [DW:0] outq [$];
   int          out_cyc [$];

   always #5 clk = ~clk;

   image_frame_packetizer #(.DATA_W(DW), .FIFO_DEPTH(16), .LEN_W(LW), .PAD_VALUE(32'h0)) dut (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .cfg_frame_len(cfg),
      .s_data(s_data), .s_valid(s_valid), .s_eof(s_eof), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .frame_done(frame_done), .err_short(err_short), .err_long(err_long), .err_clr(err_clr));

   // Inputs change at posedge+1, so the falling edge sees stable values for the next pop.
   always @(negedge clk) begin
      cyc++;
      if (rst_n && m_valid && m_ready) begin
         outq.push_back({m_last, m_data});
         out_cyc.push_back(cyc);
      end
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic eof);
      bit acc = 0;
      s_data = d; s_eof = eof; s_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (s_ready) begin acc = 1; break; end
      end
      tick();
      s_valid = 1'b0; s_eof = 1'b0;
      if (!acc) begin
         total++; bad++;
         $display("FAIL send_timeout data=%h got s_ready=0 want 1", d);
      end
   endtask

   task automatic clear_errs();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
   endtask

   task automatic test_reset();
      cfg = 24'd4; m_ready = 1'b1; rst_n = 1'b0;
      @(negedge clk);
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
      tick(); tick(); rst_n = 1'b1;
      @(negedge clk);
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
      total++; if (m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last got=%b want=0", m_last); end
      total++; if (m_data !== 32'h0) begin bad++; $display("FAIL rst_m_data got=%h want=0", m_data); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b want=0", frame_done); end
      total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL rst_errs got=%b want=00", {err_short, err_long}); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL idle_s_ready got=%b want=1", s_ready); end
      cfg = '0; #1;
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL cfg0_s_ready got=%b want=0", s_ready); end
      cfg = 24'd4;
      tick();
   endtask

   task automatic test_normal();
      int b = outq.size();
      int d0 = done_cnt;
      cfg = 24'd4;
      for (int k = 0; k < 4; k++) send(32'hA0 + k, k == 3);
      repeat (4) tick();
      total++; if (outq.size() - b !== 4) begin bad++; $display("FAIL norm_count got=%0d want=4", outq.size() - b); end
      else begin
         for (int k = 0; k < 4; k++) begin
            total++;
            if (outq[b+k] !== {k == 3, 32'hA0 + k}) begin bad++; $display("FAIL norm_beat%0d got=%h want=%h", k, outq[b+k], {k == 3, 32'hA0 + k}); end
         end
         total++; if (done_cyc !== out_cyc[b+3] + 1) begin bad++; $display("FAIL norm_done_time got=%0d want=%0d", done_cyc, out_cyc[b+3] + 1); end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL norm_done_cnt got=%0d want=1", done_cnt - d0); end
      total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL norm_errs got=%b want=00", {err_short, err_long}); end
   endtask

   task automatic test_short();
      int b = outq.size();
      int d0 = done_cnt;
      logic [DW:0] exp [$];
      cfg = 24'd4;
      send(32'hB0, 1'b0);
      send(32'hB1, 1'b1);
`ifdef PKT_PAD_EN
      exp = '{{1'b0, 32'hB0}, {1'b0, 32'hB1}, {1'b0, 32'h0}, {1'b1, 32'h0}};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pad_s_ready%0d got=%b want=0", k, s_ready); end
      end
`else
      exp = '{{1'b0, 32'hB0}, {1'b1, 32'hB1}};
`endif
      repeat (5) tick();
      total++; if (outq.size() - b !== exp.size()) begin bad++; $display("FAIL short_count got=%0d want=%0d", outq.size() - b, exp.size()); end
      else begin
         for (int k = 0; k < exp.size(); k++) begin
            total++;
            if (outq[b+k] !== exp[k]) begin bad++; $display("FAIL short_beat%0d got=%h want=%h", k, outq[b+k], exp[k]); end
         end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL short_done_cnt got=%0d want=1", done_cnt - d0); end
      total++; if ({err_short, err_long} !== 2'b10) begin bad++; $display("FAIL short_errs got=%b want=10", {err_short, err_long}); end
      clear_errs();
      @(negedge clk);
      total++; if (err_short !== 1'b0) begin bad++; $display("FAIL short_clr got=%b want=0", err_short); end
      tick();
   endtask

   task automatic test_long();
      int b = outq.size();
      int d0 = done_cnt;
      logic [DW:0] exp [$];
      exp = '{{1'b0, 32'hC0}, {1'b0, 32'hC1}, {1'b1, 32'hC2}, {1'b0, 32'hC3}, {1'b0, 32'hC4}, {1'b1, 32'hC5}};
      cfg = 24'd3;
      for (int k = 0; k < 5; k++) send(32'hC0 + k, 1'b0);
      cfg = 24'd8;
      send(32'hC5, 1'b1);
      repeat (4) tick();
      total++; if (outq.size() - b !== 6) begin bad++; $display("FAIL long_count got=%0d want=6", outq.size() - b); end
      else begin
         for (int k = 0; k < 6; k++) begin
            total++;
            if (outq[b+k] !== exp[k]) begin bad++; $display("FAIL long_beat%0d got=%h want=%h", k, outq[b+k], exp[k]); end
         end
      end
      total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL long_done_cnt got=%0d want=2", done_cnt - d0); end
      total++; if ({err_short, err_long} !== 2'b01) begin bad++; $display("FAIL long_errs got=%b want=01", {err_short, err_long}); end
      clear_errs();
   endtask

   task automatic test_len1();
      int b = outq.size();
      cfg = 24'd1;
      send(32'hE0, 1'b0);
      send(32'hE1, 1'b1);
      repeat (4) tick();
      total++; if (outq.size() - b !== 2) begin bad++; $display("FAIL len1_count got=%0d want=2", outq.size() - b); end
      else begin
         total++; if (outq[b] !== {1'b1, 32'hE0}) begin bad++; $display("FAIL len1_beat0 got=%h want=%h", outq[b], {1'b1, 32'hE0}); end
         total++; if (outq[b+1] !== {1'b1, 32'hE1}) begin bad++; $display("FAIL len1_beat1 got=%h want=%h", outq[b+1], {1'b1, 32'hE1}); end
      end
      total++; if ({err_short, err_long} !== 2'b01) begin bad++; $display("FAIL len1_errs got=%b want=01", {err_short, err_long}); end
      clear_errs();
   endtask

   task automatic test_full();
      int b = outq.size();
      int acc = 0;
      cfg = 24'd100; m_ready = 1'b0; s_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         s_data = 32'hF00 + acc;
         @(negedge clk);
         if (s_ready) acc++;
         tick();
      end
      total++; if (acc !== 16) begin bad++; $display("FAIL full_accepted got=%0d want=16", acc); end
      @(negedge clk);
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_s_ready got=%b want=0", s_ready); end
      total++; if (m_data !== 32'hF00) begin bad++; $display("FAIL full_head_held got=%h want=%h", m_data, 32'hF00); end
      tick();
      m_ready = 1'b1;
      @(negedge clk);
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_pop_s_ready got=%b want=0", s_ready); end
      tick();
      s_valid = 1'b0;
      repeat (20) tick();
      total++; if (outq.size() - b !== 16) begin bad++; $display("FAIL drain_count got=%0d want=16", outq.size() - b); end
      else begin
         for (int k = 0; k < 16; k++) begin
            total++;
            if (outq[b+k] !== {1'b0, 32'hF00 + k}) begin bad++; $display("FAIL drain_beat%0d got=%h want=%h", k, outq[b+k], {1'b0, 32'hF00 + k}); end
         end
         total++; if (out_cyc[b+15] - out_cyc[b] !== 15) begin bad++; $display("FAIL drain_rate got=%0d want=15", out_cyc[b+15] - out_cyc[b]); end
      end
   endtask

   task automatic test_reset_mid();
      int b;
      int d0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      cfg = 24'd8; m_ready = 1'b0;
      send(32'h100, 1'b0);
      send(32'h101, 1'b0);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      @(negedge clk);
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_m_valid got=%b want=0", m_valid); end
      total++; if (m_data !== 32'h0) begin bad++; $display("FAIL rstmid_m_data got=%h want=0", m_data); end
      tick();
      b = outq.size(); d0 = done_cnt;
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) send(32'h200 + k, k == 7);
      repeat (4) tick();
      total++; if (outq.size() - b !== 8) begin bad++; $display("FAIL rstmid_count got=%0d want=8", outq.size() - b); end
      else begin
         for (int k = 0; k < 8; k++) begin
            total++;
            if (outq[b+k] !== {k == 7, 32'h200 + k}) begin bad++; $display("FAIL rstmid_beat%0d got=%h want=%h", k, outq[b+k], {k == 7, 32'h200 + k}); end
         end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rstmid_done_cnt got=%0d want=1", done_cnt - d0); end
      total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL rstmid_errs got=%b want=00", {err_short, err_long}); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_normal();
      test_short();
      test_long();
      test_len1();
      test_full();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/image_frame_packetizer.md
# image_frame_packetizer

Frame packetizer between the image processing core and the AXI4-Stream master output stage (DMA-facing). Accepts a pixel stream with an upstream end-of-frame marker and buffers it in a small FIFO. Generates the output last flag from a programmed frame length, so every DMA transfer has exactly the expected beat count. Short and long frames are detected and flagged.

## Interface
Parameters:
- DATA_W, 32, pixel/word width; equals the stream data width of the output stage.
- FIFO_DEPTH, 16, buffer entries; power of 2, at least 4.
- LEN_W, 24, width of the frame-length configuration.
- PAD_VALUE, 32'h0000_0000, word written when padding short frames.

Ports:
- M_AXIS_ACLK  in  1  sole clock; everything is rising-edge.
- M_AXIS_ARESETN  in  1  synchronous, active-low reset.
- cfg_frame_len  in  LEN_W  beats per frame; sampled at frame start; 0 = disabled.
- s_data  in  DATA_W  pixel from the processing core.
- s_valid  in  1  s_data valid.
- s_eof  in  1  upstream marks the final pixel of the frame; qualified by s_valid.
- s_ready  out  1  block accepts the pixel this cycle.
- m_data  out  DATA_W  to the output stage's data_in.
- m_valid  out  1  to valid_in.
- m_last  out  1  to last_in.
- m_ready  in  1  from ready_out (downstream TREADY gated by reset).
- frame_done  out  1  one-cycle pulse when an m_last beat is accepted.
- err_short  out  1  sticky: frame ended by s_eof before cfg length.
- err_long  out  1  sticky: cfg length reached without s_eof.
- err_clr  in  1  clears both sticky errors (set wins if same cycle).

## Operation
- Write side FSM: IDLE, STREAM, PAD.
- IDLE: on an accepted beat, latch cfg_frame_len into len_q, set beat_cnt=0, process the beat as STREAM does, and go to STREAM (or stay in IDLE if the beat closes the frame).
- A beat is accepted when s_valid && s_ready. s_ready = !fifo_full && state!=PAD && (state!=IDLE || cfg_frame_len!=0).
- Each accepted beat writes {last, data} into the FIFO and increments beat_cnt (LEN_W bits). last=1 iff beat_cnt==len_q-1.
- Normal close: the beat at len_q-1 with s_eof=1 writes last=1 and goes to IDLE.
- Long frame: the beat at len_q-1 with s_eof=0 writes last=1, sets err_long, and goes to IDLE. The following pixels start a new frame.
- Short frame (s_eof=1, beat_cnt<len_q-1): sets err_short; behaviour depends on PKT_PAD_EN (see Configuration).
- len_q==1: every accepted beat writes last=1.
- Read side: m_valid = FIFO not empty; {m_last, m_data} = head entry. Pop on m_valid && m_ready. Head is held stable while m_ready=0.
- frame_done pulses the cycle after a pop with m_last=1.

## Timing
- Reset values: s_ready=0 for the reset cycle, m_valid=0, m_last=0, m_data=0, frame_done=0, err_*=0. Reset also sets state IDLE, beat_cnt=0, and empties the FIFO.
- Latency: a beat written at edge N is visible on m_valid/m_data after edge N (cycle N+1). No combinational s_→m_ path.
- Full FIFO: s_ready=0, even if a pop occurs in the same cycle (no write-through on full). Simultaneous push and pop when not full or empty keeps the occupancy unchanged.
- Reset mid-frame: partial frame discarded; no last emitted; the next beat after reset starts a new frame.
- cfg_frame_len changes mid-frame have no effect until the next IDLE→frame start.
- Throughput: 1 beat/cycle sustained when m_ready=1.

## Configuration
- PKT_PAD_EN defined: on a short s_eof, write that beat with last=0 and enter PAD. PAD writes PAD_VALUE at 1 word/cycle whenever the FIFO is not full, incrementing beat_cnt. The word at len_q-1 carries last=1, and the FSM then returns to IDLE. s_ready=0 throughout PAD.
- PKT_PAD_EN undefined: the short s_eof beat is written with last=1 and the FSM goes to IDLE. The PAD state is absent, and the frame is truncated.
- err_short is set in both builds.

## Structure
- Shared package image_pkg: PKT_STATE_T enum (IDLE/STREAM/PAD), LEN_W default, and the width of the FIFO entry record {last, data}.
- Sub-module image_sync_fifo (parameters WIDTH, DEPTH): single-clock FIFO with the same synchronous active-low reset, outputs full/empty. The packetizer is the FSM plus counter wrapped around it.

## Test plan
- len=4, 4 beats with eof on the 4th, m_ready=1: outputs D0..D3 with m_last only on D3; frame_done one cycle after; no errors.
- len=4, eof on beat 2, PKT_PAD_EN: outputs D0, D1, 0, 0 with last on the 4th beat; err_short=1; s_ready=0 during 2 PAD cycles.
- Same stimulus, no macro: outputs D0, D1 with last on D1; err_short=1.
- len=3, 5 beats with no eof: last on beat 3; err_long=1; beats 4–5 begin the next frame.
- m_ready=0 with 20 beats offered, DEPTH=16: exactly 16 accepted, s_ready=0 after; m_data held. Release m_ready: drains in order, 1 beat/cycle.
- Reset asserted after 2 beats of len=8: m_valid=0 next cycle, FIFO empty; a new frame of 8 gives last on its 8th beat.
